// File: rtl/mxv_pkg.sv
// mxv_pkg: shared definitions for the matrix-vector sequencer.
//   - state_e      : controller states
//   - MXV_MAX_SIZE : default maximum matrix dimension
//   - MXV_NUM_PE   : default number of row FIFOs / MAC units
//   - cnt_w()      : counter width for a given maximum dimension
package mxv_pkg;

  localparam int MXV_MAX_SIZE = 8;
  localparam int MXV_NUM_PE   = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_VEC  = 3'd1,
    LOAD_ROWS = 3'd2,
    COMPUTE   = 3'd3,
    RESULT    = 3'd4
  } state_e;

  // Wide enough to hold MAX_SIZE itself, not just MAX_SIZE-1.
  function automatic int cnt_w(input int max_size);
    return $clog2(max_size) + 1;
  endfunction

endpackage

// File: rtl/mxv_wrap_counter.sv
// mxv_wrap_counter: up-counter that wraps to zero after reaching a runtime
// terminal value.
// Ports:
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset
//   en_i    : advance the count (wraps to 0 when the count equals term_i)
//   clr_i   : force the count to 0 (priority over en_i)
//   term_i  : terminal value
//   cnt_o   : current count
//   tc_o    : current count equals term_i
module mxv_wrap_counter
  import mxv_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc_o  = (cnt_q == term_i);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mxv_sequencer.sv
// mxv_sequencer: controller for the matrix-vector multiply datapath.
// It loads the vector into the vector RAM, then streams matrix rows (row-major)
// into NUM_PE row FIFOs in groups. Every row is padded with zeros to MAX_SIZE
// words. It then runs the PE MAC/pop phase and hands out one result per valid
// row of the group.
// Ports:
//   clk, reset (sync, active-low)  : clock and reset
//   start, matrix_size             : begin an operation with N = matrix_size
//   in_valid / in_ready            : input stream handshake
//   vec_we, vec_addr               : vector RAM write strobe and address
//   push, pad_zero                 : one-hot FIFO push; pad_zero selects zero data
//   pe_clear, pe_pop               : MAC accumulator clear / pop-and-accumulate
//   result_valid/ready, result_sel : result handshake and PE index
//   busy, done, cfg_err            : status (done and cfg_err are single-cycle pulses)
// Build option: define MXV_SEQ_ABORT_EN to add the 'abort' input. It returns
// the controller to IDLE from any busy state without a done pulse.
module mxv_sequencer
  import mxv_pkg::*;
#(
  parameter  int MAX_SIZE = MXV_MAX_SIZE,
  parameter  int NUM_PE   = MXV_NUM_PE,
  localparam int CNT_W    = cnt_w(MAX_SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        matrix_size,
`ifdef MXV_SEQ_ABORT_EN
  input  logic              abort,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  output logic              vec_we,
  output logic [CNT_W-1:0]  vec_addr,
  output logic [NUM_PE-1:0] push,
  output logic              pad_zero,
  output logic              pe_clear,
  output logic              pe_pop,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [CNT_W-1:0]  result_sel,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam logic [CNT_W-1:0]  MAX_M1  = CNT_W'(MAX_SIZE - 1);
  localparam logic [CNT_W-1:0]  PE_M1   = CNT_W'(NUM_PE - 1);
  localparam logic [CNT_W-1:0]  PE_STEP = CNT_W'(NUM_PE);
  localparam logic [CNT_W-1:0]  ONE     = CNT_W'(1);
  localparam logic [NUM_PE-1:0] PUSH0   = NUM_PE'(1);
  localparam logic [7:0]        MAX_8   = 8'(MAX_SIZE);

  state_e           state_q;
  logic [CNT_W-1:0] n_q;      // latched matrix dimension
  logic [CNT_W-1:0] grp_q;    // first row index of the current group
  logic             cfg_err_q;

  logic [CNT_W-1:0] idx_cnt, col_cnt, row_cnt, cmp_cnt, res_cnt;
  logic             idx_tc, col_tc, row_tc, cmp_tc, res_tc;

  logic             abort_act;
  logic             size_ok;
  logic             in_vec, in_rows, in_cmp, in_res;
  logic             vec_hs, row_step, res_hs, last_hs;
  logic             pad, more_rows;
  logic [CNT_W:0]   row_abs;
  logic [CNT_W-1:0] rem_rows, last_sel;

`ifdef MXV_SEQ_ABORT_EN
  assign abort_act = abort && (state_q != IDLE);
`else
  assign abort_act = 1'b0;
`endif

  assign size_ok = (matrix_size != 8'd0) && (matrix_size <= MAX_8);

  assign in_vec  = (state_q == LOAD_VEC);
  assign in_rows = (state_q == LOAD_ROWS);
  assign in_cmp  = (state_q == COMPUTE);
  assign in_res  = (state_q == RESULT);

  // Rows beyond N and columns beyond N are zero-filled without consuming input.
  assign row_abs = {1'b0, grp_q} + {1'b0, row_cnt};
  assign pad     = (col_cnt >= n_q) || (row_abs >= {1'b0, n_q});

  // Only rows below N are presented; the group's last valid PE ends RESULT.
  assign rem_rows  = n_q - grp_q;
  assign last_sel  = (rem_rows > PE_M1) ? PE_M1 : rem_rows - ONE;
  assign more_rows = ({1'b0, grp_q} + {1'b0, PE_STEP}) < {1'b0, n_q};

  assign vec_hs   = in_vec & in_valid;
  assign row_step = in_rows & (pad | in_valid);
  assign res_hs   = in_res & result_ready;
  assign last_hs  = res_hs & res_tc;

  assign in_ready     = in_vec | (in_rows & ~pad);
  assign vec_we       = vec_hs;
  assign vec_addr     = idx_cnt;
  assign push         = row_step ? (PUSH0 << row_cnt) : '0;
  assign pad_zero     = in_rows & pad;
  assign pe_pop       = in_cmp;
  assign pe_clear     = in_cmp & (cmp_cnt == '0);
  assign result_valid = in_res;
  assign result_sel   = res_cnt;
  assign busy         = (state_q != IDLE);
  assign done         = last_hs & ~more_rows;
  assign cfg_err      = cfg_err_q;

  mxv_wrap_counter #(.W(CNT_W)) u_idx (
    .clk_i(clk), .rst_ni(reset), .en_i(vec_hs), .clr_i(abort_act),
    .term_i(n_q - ONE), .cnt_o(idx_cnt), .tc_o(idx_tc)
  );

  mxv_wrap_counter #(.W(CNT_W)) u_col (
    .clk_i(clk), .rst_ni(reset), .en_i(row_step), .clr_i(abort_act),
    .term_i(MAX_M1), .cnt_o(col_cnt), .tc_o(col_tc)
  );

  // Row within the group; equals the target FIFO index.
  mxv_wrap_counter #(.W(CNT_W)) u_row (
    .clk_i(clk), .rst_ni(reset), .en_i(row_step & col_tc), .clr_i(abort_act),
    .term_i(PE_M1), .cnt_o(row_cnt), .tc_o(row_tc)
  );

  mxv_wrap_counter #(.W(CNT_W)) u_cmp (
    .clk_i(clk), .rst_ni(reset), .en_i(in_cmp), .clr_i(abort_act),
    .term_i(MAX_M1), .cnt_o(cmp_cnt), .tc_o(cmp_tc)
  );

  mxv_wrap_counter #(.W(CNT_W)) u_res (
    .clk_i(clk), .rst_ni(reset), .en_i(res_hs), .clr_i(abort_act),
    .term_i(last_sel), .cnt_o(res_cnt), .tc_o(res_tc)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      n_q       <= '0;
      grp_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      if (abort_act) begin
        state_q <= IDLE;
        grp_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              if (size_ok) begin
                n_q     <= CNT_W'(matrix_size);
                grp_q   <= '0;
                state_q <= LOAD_VEC;
              end else begin
                cfg_err_q <= 1'b1;
              end
            end
          end
          LOAD_VEC:  if (vec_hs && idx_tc) state_q <= LOAD_ROWS;
          LOAD_ROWS: if (row_step && col_tc && row_tc) state_q <= COMPUTE;
          COMPUTE:   if (cmp_tc) state_q <= RESULT;
          RESULT: begin
            if (last_hs) begin
              if (more_rows) begin
                grp_q   <= grp_q + PE_STEP;
                state_q <= LOAD_ROWS;
              end else begin
                grp_q   <= '0;
                state_q <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mxv_sequencer.sv
module tb_mxv_sequencer;

  localparam int MAXS = 8;
  localparam int NPE  = 4;
  localparam int CW   = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [7:0]     matrix_size = 8'd0;
`ifdef MXV_SEQ_ABORT_EN
  logic           abort = 1'b0;
`endif
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           vec_we;
  logic [CW-1:0]  vec_addr;
  logic [NPE-1:0] push;
  logic           pad_zero;
  logic           pe_clear;
  logic           pe_pop;
  logic           result_valid;
  logic           result_ready = 1'b1;
  logic [CW-1:0]  result_sel;
  logic           busy;
  logic           done;
  logic           cfg_err;

  mxv_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .matrix_size(matrix_size),
`ifdef MXV_SEQ_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .vec_we(vec_we), .vec_addr(vec_addr),
    .push(push), .pad_zero(pad_zero), .pe_clear(pe_clear), .pe_pop(pe_pop),
    .result_valid(result_valid), .result_ready(result_ready), .result_sel(result_sel),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int  n;
    bit  rnd;    // random in_valid
    bit  stall;  // hold result_ready low for 5 cycles
    bit  spam;   // keep start high (with another size) while busy
    int  kill;   // 0 none, 1 reset in COMPUTE, 2 abort in LOAD_VEC
  } op_t;

  typedef struct {
    bit         st;
    logic [7:0] size;
    bit         exp_err;
    bit         exp_busy;
  } cfg_t;

  int          errors = 0;
  int          checks = 0;
  bit          mon_en = 1'b0;
  bit          stall_prev = 1'b0;
  logic [CW-1:0] prev_sel = '0;
  logic [15:0] sbq[$];

  function automatic logic [15:0] ev(input int k, input int d);
    return 16'(((k & 15) << 12) | (d & 12'hFFF));
  endfunction

  function automatic int outs();
    return int'({in_ready, vec_we, vec_addr, push, pad_zero, pe_clear, pe_pop,
                 result_valid, result_sel, busy, done, cfg_err});
  endfunction

  task automatic chk(input int act, input int exp, input string name);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_ev(input logic [15:0] act, input string name);
    logic [15:0] exp;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event %h, none expected at %0t", name, act, $time);
    end else begin
      exp = sbq.pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: got event %h expected %h at %0t", name, act, exp, $time);
      end
    end
  endtask

  task automatic sample();
    if (vec_we) check_ev(ev(1, int'(vec_addr)), "vec");
    if (|push) check_ev(ev(2, int'(pad_zero) * 16 + int'(push)), "push");
    if (pe_pop) check_ev(ev(3, int'(pe_clear)), "pop");
    if (result_valid && result_ready) check_ev(ev(4, int'(result_sel)), "result");
    if (done) check_ev(ev(5, 0), "done");
    if (pad_zero) chk(int'(in_ready), 0, "pad_no_ready");
    if (stall_prev) chk(int'(result_sel), int'(prev_sel), "stall_hold");
    stall_prev = result_valid && !result_ready;
    prev_sel   = result_sel;
  endtask

  task automatic at_neg();
    @(negedge clk);
    if (mon_en) sample();
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  // Expected event stream of one complete operation.
  task automatic build(input int n);
    for (int a = 0; a < n; a++) sbq.push_back(ev(1, a));
    for (int g = 0; g < n; g += NPE) begin
      for (int r = 0; r < NPE; r++)
        for (int c = 0; c < MAXS; c++)
          sbq.push_back(ev(2, ((c >= n) || (g + r >= n) ? 16 : 0) + (1 << r)));
      for (int c = 0; c < MAXS; c++) sbq.push_back(ev(3, (c == 0) ? 1 : 0));
      for (int r = 0; r < NPE; r++)
        if (g + r < n) sbq.push_back(ev(4, r));
    end
    sbq.push_back(ev(5, 0));
  endtask

  task automatic run_op(input op_t op);
    int cyc;
    int stall_left;
    bit seen_res;
    bit killed;
    cyc = 0; stall_left = op.stall ? 5 : 0; seen_res = 0; killed = 0;
    build(op.n);
    start = 1'b1; matrix_size = 8'(op.n); in_valid = 1'b1; result_ready = 1'b1;
    while (sbq.size() != 0 && cyc < 3000) begin
      at_neg();
      if (op.kill == 1 && pe_pop) begin
        mon_en = 1'b0;
        to_pos(); reset = 1'b0;
        to_pos(); reset = 1'b1;
        at_neg(); chk(outs(), 0, "reset_mid_outs");
        killed = 1;
        break;
      end
`ifdef MXV_SEQ_ABORT_EN
      if (op.kill == 2 && vec_we && vec_addr == 4'd1) begin
        mon_en = 1'b0;
        to_pos(); abort = 1'b1; start = 1'b1;
        to_pos(); abort = 1'b0; start = 1'b0;
        at_neg(); chk(outs(), 0, "abort_outs");
        killed = 1;
        break;
      end
`endif
      if (result_valid) seen_res = 1;
      to_pos();
      start = op.spam && !seen_res;
      if (op.spam) matrix_size = 8'd2;
      in_valid = op.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (result_valid && stall_left > 0) begin
        result_ready = 1'b0; stall_left--;
      end else begin
        result_ready = 1'b1;
      end
      cyc++;
    end
    start = 1'b0; in_valid = 1'b0; result_ready = 1'b1;
    if (killed) begin
      sbq.delete(); stall_prev = 1'b0; mon_en = 1'b1;
      to_pos();
    end else if (sbq.size() != 0) begin
      errors++; checks++;
      $display("FAIL timeout n=%0d: %0d events outstanding, 0 required", op.n, sbq.size());
      sbq.delete();
    end else begin
      to_pos();
      at_neg();
      chk(int'({busy, done}), 0, "idle_after_done");
      to_pos();
    end
  endtask

  initial begin
    op_t  ops[$];
    cfg_t cfgs[$];

    cfgs.push_back('{1'b1, 8'd0,   1'b1, 1'b0});
    cfgs.push_back('{1'b1, 8'd9,   1'b1, 1'b0});
    cfgs.push_back('{1'b1, 8'd255, 1'b1, 1'b0});
    cfgs.push_back('{1'b0, 8'd4,   1'b0, 1'b0});
    cfgs.push_back('{1'b0, 8'd0,   1'b0, 1'b0});

    ops.push_back('{4, 1'b0, 1'b0, 1'b0, 0});
    ops.push_back('{8, 1'b0, 1'b0, 1'b0, 0});
    ops.push_back('{3, 1'b0, 1'b0, 1'b0, 0});
    ops.push_back('{4, 1'b0, 1'b0, 1'b1, 0});
    ops.push_back('{5, 1'b1, 1'b1, 1'b0, 0});
    ops.push_back('{8, 1'b0, 1'b0, 1'b0, 1});
    ops.push_back('{2, 1'b0, 1'b0, 1'b0, 0});
    ops.push_back('{1, 1'b1, 1'b1, 1'b0, 0});
`ifdef MXV_SEQ_ABORT_EN
    ops.push_back('{4, 1'b0, 1'b0, 1'b0, 2});
    ops.push_back('{2, 1'b0, 1'b0, 1'b0, 0});
`endif

    // Reset state
    reset = 1'b0;
    to_pos(); to_pos();
    at_neg(); chk(outs(), 0, "reset_outs");
    to_pos();
    reset = 1'b1;
    at_neg(); chk(outs(), 0, "idle_outs");
    to_pos();

    // Configuration errors and idle behaviour
    foreach (cfgs[i]) begin
      start = cfgs[i].st; matrix_size = cfgs[i].size;
      at_neg(); chk(int'(cfg_err), 0, "cfg_err_early");
      to_pos(); start = 1'b0;
      at_neg();
      chk(int'(cfg_err), int'(cfgs[i].exp_err), "cfg_err");
      chk(int'(busy), int'(cfgs[i].exp_busy), "cfg_busy");
      to_pos();
      at_neg(); chk(int'(cfg_err), 0, "cfg_err_pulse");
      to_pos();
    end

    mon_en = 1'b1;
    foreach (ops[i]) run_op(ops[i]);
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
